// File: rtl/mac_result_buffer_pkg.sv
// -----------------------------------------------------------------------------
// mac_result_buffer_pkg
// Shared constants for the MAC result buffer and the a*b+c MAC stage it serves.
//   DROP_CNT_W   : width of the dropped-result counter
//   DROP_CNT_MAX : saturation value of the dropped-result counter
//   MAC_DATA_W   : default result width, equal to the MAC data_out width
// -----------------------------------------------------------------------------
package mac_result_buffer_pkg;
  localparam int                    DROP_CNT_W   = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;
  localparam int                    MAC_DATA_W   = 32;
endpackage

// File: rtl/mac_result_buffer_mem.sv
// -----------------------------------------------------------------------------
// mac_result_buffer_mem
// DEPTH x WIDTH register array, one write port and one asynchronous read port.
// The contents are never reset; the parent tracks which entries are valid.
// Ports:
//   clk     : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write address (parent write pointer)
//   wr_data : write data
//   rd_addr : read address (parent head pointer)
//   rd_data : contents of rd_addr
// -----------------------------------------------------------------------------
module mac_result_buffer_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mac_result_buffer.sv
// -----------------------------------------------------------------------------
// mac_result_buffer
// Captures every result strobed by the MAC (which cannot be stalled) into a
// small FIFO and re-issues it on a show-ahead ready/valid interface. Results
// arriving while the FIFO is full (and not being popped) are dropped, counted
// in a saturating counter and flagged in a sticky overflow bit.
//
// Optional feature, enabled by defining MAC_RESULT_BUFFER_SUM_EN:
//   adds sum_out, the modulo-2^WIDTH running sum of every popped result,
//   cleared by rst and flush.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, highest priority
//   in_valid  : result strobe (MAC valido)
//   in_data   : result value (MAC data_out)
//   flush     : synchronous FIFO clear; same-cycle push/pop are discarded
//   out_valid : head entry available (registered)
//   out_ready : consumer accepts head entry
//   out_data  : head entry value, held while out_valid=0
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, a result was dropped since reset
//   drop_cnt  : saturating count of dropped results
//   sum_out   : running sum of popped data (MAC_RESULT_BUFFER_SUM_EN only)
// -----------------------------------------------------------------------------
module mac_result_buffer
  import mac_result_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = MAC_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`ifdef MAC_RESULT_BUFFER_SUM_EN
  ,
  output logic [WIDTH-1:0]        sum_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  pop, push, drop, wr_en;
  logic [CW-1:0]         remain;
  logic [WIDTH-1:0]      rd_data;

  mac_result_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_d),
    .rd_data (rd_data)
  );

  always_comb begin
    pop   = out_valid_q & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push  = in_valid & ((count_q != CNT_FULL) | pop);
    drop  = in_valid & (count_q == CNT_FULL) & ~pop & ~flush;
    wr_en = push & ~flush;
    // Entries left once this cycle's pop (if any) is retired.
    remain = count_q - CW'(pop);

    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q | drop;
    drop_cnt_d  = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = remain + CW'(push);
      // The new head is the entry being written this cycle when nothing else
      // remains; the array only holds it after the edge, so take in_data.
      if (count_d != '0) begin
        out_data_d = (remain == '0) ? in_data : rd_data;
      end
    end

    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef MAC_RESULT_BUFFER_SUM_EN
  logic [WIDTH-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + out_data_q;
    end
  end

  assign sum_out = sum_q;
`endif

endmodule

// File: tb/tb_mac_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_mac_result_buffer
// Scoreboard bench: a reference process keeps the FIFO contents as a queue of
// accepted results; a monitor compares DUT outputs to it every cycle and pops
// the queue on each handshake.
// -----------------------------------------------------------------------------
module tb_mac_result_buffer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       count;
  logic             overflow;
  logic [15:0]      drop_cnt;
`ifdef MAC_RESULT_BUFFER_SUM_EN
  logic [WIDTH-1:0] sum_out;
`endif

  mac_result_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`ifdef MAC_RESULT_BUFFER_SUM_EN
    ,
    .sum_out   (sum_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] e_last   = '0;
  int               e_drops  = 0;
  bit               e_ovf    = 1'b0;
  bit               pop_flag = 1'b0;
`ifdef MAC_RESULT_BUFFER_SUM_EN
  logic [WIDTH-1:0] e_sum    = '0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: applies the buffering rules at every rising edge.
  initial begin
    int sz_before;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        e_drops = 0;
        e_ovf   = 1'b0;
        e_last  = '0;
`ifdef MAC_RESULT_BUFFER_SUM_EN
        e_sum   = '0;
`endif
      end else begin
        sz_before = exp_q.size() + (pop_flag ? 1 : 0);
        if (flush) begin
          exp_q.delete();
`ifdef MAC_RESULT_BUFFER_SUM_EN
          e_sum = '0;
`endif
        end else if (in_valid && (sz_before < DEPTH || pop_flag)) begin
          exp_q.push_back(in_data);
        end else if (in_valid) begin
          e_ovf = 1'b1;
          if (e_drops != 65535) e_drops++;
        end
        if (!flush && exp_q.size() != 0) e_last = exp_q[0];
      end
      pop_flag = 1'b0;
    end
  end

  // Monitor: compares outputs mid-cycle and retires handshaked entries.
  initial begin
    logic [WIDTH-1:0] d;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("count",     64'(count),     64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("out_data",  64'(out_data),  64'(e_last));
      chk("overflow",  64'(overflow),  64'(e_ovf));
      chk("drop_cnt",  64'(drop_cnt),  64'(e_drops));
`ifdef MAC_RESULT_BUFFER_SUM_EN
      chk("sum_out",   64'(sum_out),   64'(e_sum));
`endif
      if (out_valid && out_ready && !flush && !rst) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_empty at %0t: got out_valid=1 expected no entry", $time);
        end else begin
          d = exp_q.pop_front();
          chk("pop_data", 64'(out_data), 64'(d));
`ifdef MAC_RESULT_BUFFER_SUM_EN
          e_sum = e_sum + d;
`endif
          pop_flag = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit rdy,
                       input bit fl, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Single push, held with no consumer
    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);

    // Streaming with the consumer always ready
    drive(1'b1, 32'd10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd20, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd30, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Overfill by one, then drain
    for (int i = 1; i <= 9; i++) drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    idle(11, 1'b1);

    // Full FIFO with simultaneous push and pop, long enough to wrap pointers
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd99, 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1);

    // Second drop, trim to 3 entries, flush with a colliding push, then reset
    for (int i = 0; i < 9; i++) drive(1'b1, 32'(200 + i), 1'b0, 1'b0, 1'b0);
    idle(5, 1'b1);
    idle(1, 1'b0);
    drive(1'b1, 32'd555, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Running-sum wrap, then flush
    drive(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b1);
    drive(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) == 0));
    end
    idle(12, 1'b1);
    idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
